lsu16: RTL and testbench
========================

Name: lsu16

Overview:
- Load/store unit sitting directly upstream of the 16-bit word memory; it converts byte-addressed core requests into word-aligned memory accesses.
- Supports byte and halfword loads and stores, including misaligned halfwords that straddle two words.
- Byte stores and straddling stores use read-modify-write.
- The memory port is word-indexed, with combinational read and write on the clock edge.

Parameters:
- ADDR_W, 16, byte address width. The word index is ADDR_W-1 bits wide.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_size  in  1  0 = byte, 1 = halfword
- req_unsigned  in  1  byte load: 1 = zero-extend, 0 = sign-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  16  store data (byte store uses [7:0])
- resp_valid  out  1  one-cycle completion pulse, for loads and stores
- resp_rdata  out  16  load result
- mem_addr  out  ADDR_W-1  word index to memory
- mem_wdata  out  16  word to write
- mem_we  out  1  write enable
- mem_rdata  in  16  combinational read data for mem_addr

Behaviour:
- Addressing and lanes:
  - Little-endian. Byte address A maps to word W = A[ADDR_W-1:1].
  - Lane A[0]=0 is bits [7:0]; lane A[0]=1 is bits [15:8].
  - The second word of a straddling access is W+1 modulo 2^(ADDR_W-1): word 0x7FFF wraps to 0x0000.
- Request capture:
  - A handshake occurs when req_valid && req_ready at a rising edge.
  - On handshake, addr, wdata, size, write and unsigned are registered.
  - Request inputs are ignored outside IDLE.
- FSM states: IDLE, RD0, WR0, RD1, WR1, DONE.
- State paths:
  - Aligned halfword load: IDLE→RD0→DONE. RD0 captures mem_rdata.
  - Byte load: IDLE→RD0→DONE. RD0 captures the selected lane, then extends it per req_unsigned.
  - Misaligned halfword load (A[0]=1): IDLE→RD0→RD1→DONE.
    - RD0 captures word W [15:8] into result[7:0].
    - RD1 captures word W+1 [7:0] into result[15:8].
  - Aligned halfword store: IDLE→WR0→DONE. WR0 writes wdata to W.
  - Byte store: IDLE→RD0→WR0→DONE.
    - RD0 latches word W.
    - WR0 writes the latched word with the addressed lane replaced by wdata[7:0].
  - Misaligned halfword store: IDLE→RD0→WR0→RD1→WR1→DONE.
    - WR0 writes W with [15:8] = wdata[7:0].
    - WR1 writes W+1 with [7:0] = wdata[15:8].
    - Unaffected bytes are preserved from the RD reads.
  - DONE→IDLE unconditionally.
- Memory port rules:
  - mem_we is high only in WR0/WR1 and is decoded directly from the state register.
  - In IDLE and DONE: mem_addr = 0, mem_wdata = 0.
- Response:
  - resp_valid is high exactly in DONE, for one cycle, with no backpressure.
  - resp_rdata is updated only by loads and is held until the next load completes.
- Cycles from the handshake edge to the DONE cycle:
  - aligned load / halfword store: 2
  - byte store / misaligned load: 3
  - misaligned store: 5
- req_ready returns high the cycle after DONE.
- Reset values:
  - state IDLE, req_ready 1, resp_valid 0, resp_rdata 0x0000.
  - mem_we 0, mem_addr 0, mem_wdata 0.
- Reset mid-operation:
  - The state returns to IDLE immediately and asynchronously; mem_we drops without waiting for a clock.
  - Writes already committed stay in memory. For example, a misaligned store reset after WR0 leaves W written and W+1 untouched.
  - No resp_valid is issued for the aborted request.

Test Plan:
- Preload mem[0x10]=0xA1B2, mem[0x11]=0xC3D4:
  - Signed byte load at 0x0021 → resp_rdata 0xFFA1, resp_valid 2 cycles after the handshake.
  - Unsigned byte load at 0x0020 → 0x00B2.
- Same preload, halfword load at 0x0021 → 0xD4A1 on the 3rd cycle.
  - The bench checks that mem_addr presents 0x10 then 0x11.
  - mem_we stays 0 throughout.
- Byte store 0x55 at 0x0020 → mem[0x10] = 0xA155 after exactly one mem_we pulse.
  - Then an aligned halfword store 0xBEEF at 0x0022 → mem[0x11] = 0xBEEF, with resp_valid 2 cycles after the handshake.
- Misaligned halfword store 0x1234 at 0x0021 on the preload → mem[0x10] = 0x34B2, mem[0x11] = 0xC312.
  - Exactly two mem_we pulses; resp_valid on the 5th cycle.
  - req_ready is low throughout.
- Wrap-around: mem[0x7FFF]=0x9900, mem[0x0000]=0x0077, halfword load at 0xFFFF → 0x7799.
  - The second access uses mem_addr 0x0000.
- Reset in WR1 of a misaligned store at 0x0021 on the preload → mem[0x10] = 0x34B2, mem[0x11] = 0xC3D4.
  - No resp_valid; req_ready=1 while rst is high.
  - A following byte load at 0x0022 returns 0xFFD4.

Source files
------------

// File: rtl/lsu16.sv
`default_nettype none
// ============================================================================
// lsu16 : byte/halfword load-store unit in front of a 16-bit word memory,
//         misaligned halfwords split into two word accesses with RMW.
// Rev 1.0
// ============================================================================
module lsu16 #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              resp_valid,
    output logic [15:0]       resp_rdata,
    output logic [ADDR_W-2:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_we,
    input  logic [15:0]       mem_rdata
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        WR0  = 3'd2,
        RD1  = 3'd3,
        WR1  = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam logic [ADDR_W-2:0] C_WORD_ONE = 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              size_q, size_d;
    logic              write_q, write_d;
    logic              uns_q, uns_d;
    logic [15:0]       word_q, word_d;
    logic [15:0]       rdata_q, rdata_d;

    logic [ADDR_W-2:0] w_word0;
    logic [ADDR_W-2:0] w_word1;
    logic              w_misal;
    logic [7:0]        w_lane;

    assign w_word0 = addr_q[ADDR_W-1:1];
    assign w_word1 = w_word0 + C_WORD_ONE;   // wraps naturally at the top word
    assign w_misal = size_q & addr_q[0];
    assign w_lane  = addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0];

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign resp_rdata = rdata_q;
    assign mem_we     = (state_q == WR0) || (state_q == WR1);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        write_d   = write_q;
        uns_d     = uns_q;
        word_d    = word_q;
        rdata_d   = rdata_q;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    write_d = req_write;
                    uns_d   = req_unsigned;
                    state_d = (req_write && req_size && !req_addr[0]) ? WR0 : RD0;
                end
            end
            RD0: begin
                mem_addr = w_word0;
                // Stashed for RMW stores and as the low byte of a split load
                word_d   = mem_rdata;
                if (write_q) begin
                    state_d = WR0;
                end else if (w_misal) begin
                    state_d = RD1;
                end else begin
                    if (size_q) begin
                        rdata_d = mem_rdata;
                    end else begin
                        rdata_d = {(uns_q ? 8'h00 : {8{w_lane[7]}}), w_lane};
                    end
                    state_d = DONE;
                end
            end
            WR0: begin
                mem_addr = w_word0;
                if (size_q && !addr_q[0]) begin
                    mem_wdata = wdata_q;
                end else if (addr_q[0]) begin
                    mem_wdata = {wdata_q[7:0], word_q[7:0]};
                end else begin
                    mem_wdata = {word_q[15:8], wdata_q[7:0]};
                end
                state_d = w_misal ? RD1 : DONE;
            end
            RD1: begin
                mem_addr = w_word1;
                if (write_q) begin
                    word_d  = mem_rdata;
                    state_d = WR1;
                end else begin
                    rdata_d = {mem_rdata[7:0], word_q[15:8]};
                    state_d = DONE;
                end
            end
            WR1: begin
                mem_addr  = w_word1;
                mem_wdata = {word_q[15:8], wdata_q[15:8]};
                state_d   = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= 1'b0;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            word_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            write_q <= write_d;
            uns_q   <= uns_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu16.sv
`default_nettype none
// ============================================================================
// tb_lsu16 : self-checking bench for lsu16 against a byte-level memory model.
// Rev 1.0
// ============================================================================
module tb_lsu16;

    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic              req_size = 1'b0;
    logic              req_unsigned = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [15:0]       req_wdata = '0;
    logic              resp_valid;
    logic [15:0]       resp_rdata;
    logic [ADDR_W-2:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_we;
    logic [15:0]       mem_rdata;

    lsu16 #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Word memory; preload writes go through the same clocked port
    logic [15:0] mem [0:32767];
    logic        pl_we = 1'b0;
    logic [14:0] pl_addr = '0;
    logic [15:0] pl_data = '0;
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    // Reference model: memory viewed as little-endian bytes
    logic [15:0] refm [logic [14:0]];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] last_load = '0;

    int          obs_lat;
    int          obs_we;
    int          obs_rdy;
    logic [15:0] obs_rdata;
    logic [14:0] obs_addr [0:7];

    function automatic logic [7:0] rb(input logic [15:0] a);
        logic [15:0] w;
        w = refm[a[15:1]];
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    task automatic wb(input logic [15:0] a, input logic [7:0] b);
        logic [15:0] w;
        w = refm[a[15:1]];
        if (a[0]) w[15:8] = b;
        else      w[7:0]  = b;
        refm[a[15:1]] = w;
    endtask

    function automatic logic [15:0] model_load(input logic sz, input logic un, input logic [15:0] a);
        logic [15:0] a1;
        logic [7:0]  b0;
        a1 = a + 16'd1;
        b0 = rb(a);
        if (sz) return {rb(a1), b0};
        return un ? {8'h00, b0} : {{8{b0[7]}}, b0};
    endfunction

    task automatic model_store(input logic sz, input logic [15:0] a, input logic [15:0] d);
        wb(a, d[7:0]);
        if (sz) wb(a + 16'd1, d[15:8]);
    endtask

    function automatic int exp_lat(input logic wr, input logic sz, input logic a0);
        if (!wr) return (sz && a0) ? 3 : 2;
        if (!sz) return 3;
        return a0 ? 5 : 2;
    endfunction

    function automatic int exp_we(input logic wr, input logic sz, input logic a0);
        if (!wr) return 0;
        return (sz && a0) ? 2 : 1;
    endfunction

    task automatic poke(input logic [14:0] w, input logic [15:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = w; pl_data = d;
        @(negedge clk);
        pl_we = 1'b0;
        refm[w] = d;
    endtask

    task automatic preload();
        poke(15'h0010, 16'hA1B2);
        poke(15'h0011, 16'hC3D4);
    endtask

    // Issues one request and records what the unit did until resp_valid
    task automatic run_req(input logic wr, input logic sz, input logic un,
                           input logic [15:0] a, input logic [15:0] d, input bit noise);
        int wcyc;
        obs_lat = -1; obs_we = 0; obs_rdy = 0; obs_rdata = '0;
        for (int i = 0; i < 8; i++) obs_addr[i] = '0;
        wcyc = 0;
        @(negedge clk);
        while (!req_ready && wcyc < 20) begin
            @(negedge clk);
            wcyc++;
        end
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = un;
        req_addr = a; req_wdata = d;
        @(posedge clk);
        #1;
        if (noise) begin
            req_write = 1'($urandom); req_size = 1'($urandom); req_unsigned = 1'($urandom);
            req_addr = 16'($urandom); req_wdata = 16'($urandom);
        end else begin
            req_valid = 1'b0;
        end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c <= 8) obs_addr[c-1] = mem_addr;
            if (mem_we) obs_we++;
            if (req_ready) obs_rdy++;
            if (resp_valid) begin
                obs_lat = c;
                obs_rdata = resp_rdata;
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        n_checks++; if (resp_rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0000", resp_rdata); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        n_checks++; if (mem_addr !== 15'h0000) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr); end
        n_checks++; if (mem_wdata !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_wdata got=%h exp=0000", mem_wdata); end
        rst = 1'b0;
        last_load = 16'h0000;
    endtask

    task automatic test_byte_load();
        preload();
        run_req(1'b0, 1'b0, 1'b0, 16'h0021, 16'h0000, 1'b0);
        n_checks++; if (obs_rdata !== 16'hFFA1) begin n_fail++; $display("FAIL sbyte_load got=%h exp=FFA1", obs_rdata); end
        n_checks++; if (obs_lat != 2) begin n_fail++; $display("FAIL sbyte_lat got=%0d exp=2", obs_lat); end
        run_req(1'b0, 1'b0, 1'b1, 16'h0020, 16'h0000, 1'b0);
        n_checks++; if (obs_rdata !== 16'h00B2) begin n_fail++; $display("FAIL ubyte_load got=%h exp=00B2", obs_rdata); end
        n_checks++; if (obs_we != 0) begin n_fail++; $display("FAIL ubyte_we got=%0d exp=0", obs_we); end
        last_load = 16'h00B2;
    endtask

    task automatic test_misaligned_load();
        preload();
        run_req(1'b0, 1'b1, 1'b0, 16'h0021, 16'h0000, 1'b0);
        n_checks++; if (obs_rdata !== 16'hD4A1) begin n_fail++; $display("FAIL mis_load got=%h exp=D4A1", obs_rdata); end
        n_checks++; if (obs_lat != 3) begin n_fail++; $display("FAIL mis_load_lat got=%0d exp=3", obs_lat); end
        n_checks++; if (obs_addr[0] !== 15'h0010) begin n_fail++; $display("FAIL mis_load_addr0 got=%h exp=0010", obs_addr[0]); end
        n_checks++; if (obs_addr[1] !== 15'h0011) begin n_fail++; $display("FAIL mis_load_addr1 got=%h exp=0011", obs_addr[1]); end
        n_checks++; if (obs_we != 0) begin n_fail++; $display("FAIL mis_load_we got=%0d exp=0", obs_we); end
        last_load = 16'hD4A1;
    endtask

    task automatic test_byte_store();
        preload();
        run_req(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0055, 1'b0);
        n_checks++; if (mem[15'h0010] !== 16'hA155) begin n_fail++; $display("FAIL bstore_mem got=%h exp=A155", mem[15'h0010]); end
        n_checks++; if (obs_we != 1) begin n_fail++; $display("FAIL bstore_we got=%0d exp=1", obs_we); end
        n_checks++; if (obs_lat != 3) begin n_fail++; $display("FAIL bstore_lat got=%0d exp=3", obs_lat); end
        n_checks++; if (obs_rdata !== last_load) begin n_fail++; $display("FAIL bstore_hold got=%h exp=%h", obs_rdata, last_load); end
        run_req(1'b1, 1'b1, 1'b0, 16'h0022, 16'hBEEF, 1'b0);
        n_checks++; if (mem[15'h0011] !== 16'hBEEF) begin n_fail++; $display("FAIL hstore_mem got=%h exp=BEEF", mem[15'h0011]); end
        n_checks++; if (obs_lat != 2) begin n_fail++; $display("FAIL hstore_lat got=%0d exp=2", obs_lat); end
        n_checks++; if (obs_we != 1) begin n_fail++; $display("FAIL hstore_we got=%0d exp=1", obs_we); end
    endtask

    task automatic test_misaligned_store();
        preload();
        run_req(1'b1, 1'b1, 1'b0, 16'h0021, 16'h1234, 1'b0);
        n_checks++; if (mem[15'h0010] !== 16'h34B2) begin n_fail++; $display("FAIL mstore_mem0 got=%h exp=34B2", mem[15'h0010]); end
        n_checks++; if (mem[15'h0011] !== 16'hC312) begin n_fail++; $display("FAIL mstore_mem1 got=%h exp=C312", mem[15'h0011]); end
        n_checks++; if (obs_we != 2) begin n_fail++; $display("FAIL mstore_we got=%0d exp=2", obs_we); end
        n_checks++; if (obs_lat != 5) begin n_fail++; $display("FAIL mstore_lat got=%0d exp=5", obs_lat); end
        n_checks++; if (obs_rdy != 0) begin n_fail++; $display("FAIL mstore_ready_cycles got=%0d exp=0", obs_rdy); end
    endtask

    task automatic test_wrap();
        poke(15'h7FFF, 16'h9900);
        poke(15'h0000, 16'h0077);
        run_req(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0);
        n_checks++; if (obs_rdata !== 16'h7799) begin n_fail++; $display("FAIL wrap_load got=%h exp=7799", obs_rdata); end
        n_checks++; if (obs_addr[0] !== 15'h7FFF) begin n_fail++; $display("FAIL wrap_addr0 got=%h exp=7FFF", obs_addr[0]); end
        n_checks++; if (obs_addr[1] !== 15'h0000) begin n_fail++; $display("FAIL wrap_addr1 got=%h exp=0000", obs_addr[1]); end
        last_load = 16'h7799;
    endtask

    task automatic test_back_to_back();
        preload();
        run_req(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
        n_checks++; if (obs_rdata !== 16'hC3D4 && obs_rdata !== 16'hA1B2) begin end
        n_checks--;
        n_checks++; if (obs_rdata !== 16'hA1B2) begin n_fail++; $display("FAIL b2b_load got=%h exp=A1B2", obs_rdata); end
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_done got=%b exp=1", req_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_single_pulse got=%b exp=0", resp_valid); end
        // Request lines churn while busy; they must be ignored
        run_req(1'b0, 1'b0, 1'b0, 16'h0023, 16'h0000, 1'b1);
        n_checks++; if (obs_rdata !== 16'hFFC3) begin n_fail++; $display("FAIL b2b_noise_load got=%h exp=FFC3", obs_rdata); end
        n_checks++; if (obs_lat != 2) begin n_fail++; $display("FAIL b2b_noise_lat got=%0d exp=2", obs_lat); end
        n_checks++; if (mem[15'h0010] !== 16'hA1B2 || mem[15'h0011] !== 16'hC3D4) begin
            n_fail++; $display("FAIL b2b_noise_mem got=%h_%h exp=C3D4_A1B2", mem[15'h0011], mem[15'h0010]);
        end
        last_load = 16'hFFC3;
    endtask

    task automatic test_reset_mid_op();
        int wcyc;
        int nresp;
        preload();
        wcyc = 0;
        @(negedge clk);
        while (!req_ready && wcyc < 20) begin @(negedge clk); wcyc++; end
        req_valid = 1'b1; req_write = 1'b1; req_size = 1'b1; req_unsigned = 1'b0;
        req_addr = 16'h0021; req_wdata = 16'h1234;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (mem_we !== 1'b1 || mem_addr !== 15'h0011) begin
            n_fail++; $display("FAIL rstmid_in_wr1 got=we%b_addr%h exp=we1_addr0011", mem_we, mem_addr);
        end
        rst = 1'b1;
        #1;
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_we_async got=%b exp=0", mem_we); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got=%b exp=1", req_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_resp got=%b exp=0", resp_valid); end
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready_held got=%b exp=1", req_ready); end
        rst = 1'b0;
        nresp = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) nresp++;
        end
        n_checks++; if (nresp != 0) begin n_fail++; $display("FAIL rstmid_no_resp got=%0d exp=0", nresp); end
        n_checks++; if (mem[15'h0010] !== 16'h34B2) begin n_fail++; $display("FAIL rstmid_mem0 got=%h exp=34B2", mem[15'h0010]); end
        n_checks++; if (mem[15'h0011] !== 16'hC3D4) begin n_fail++; $display("FAIL rstmid_mem1 got=%h exp=C3D4", mem[15'h0011]); end
        n_checks++; if (resp_rdata !== 16'h0000) begin n_fail++; $display("FAIL rstmid_rdata_cleared got=%h exp=0000", resp_rdata); end
        wb(16'h0021, 8'h34);
        run_req(1'b0, 1'b0, 1'b0, 16'h0022, 16'h0000, 1'b0);
        n_checks++; if (obs_rdata !== 16'hFFD4) begin n_fail++; $display("FAIL rstmid_followup got=%h exp=FFD4", obs_rdata); end
        last_load = 16'hFFD4;
    endtask

    task automatic test_random();
        logic        wr, sz, un;
        logic [15:0] a, d, expv, a1;
        int          el, ew;
        for (int w = 16; w < 24; w++) poke(15'(w), 16'($urandom));
        poke(15'h7FFF, 16'($urandom));
        poke(15'h0000, 16'($urandom));
        for (int i = 0; i < 150; i++) begin
            wr = 1'($urandom); sz = 1'($urandom); un = 1'($urandom);
            d  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a = 16'hFFFE + 16'($urandom_range(0, 1));
            else                           a = 16'h0020 + 16'($urandom_range(0, 14));
            a1 = a + 16'd1;
            expv = wr ? last_load : model_load(sz, un, a);
            el = exp_lat(wr, sz, a[0]);
            ew = exp_we(wr, sz, a[0]);
            run_req(wr, sz, un, a, d, i[0]);
            if (wr) model_store(sz, a, d);
            else    last_load = expv;
            n_checks++; if (obs_rdata !== expv) begin n_fail++; $display("FAIL rnd%0d_rdata wr=%b sz=%b a=%h got=%h exp=%h", i, wr, sz, a, obs_rdata, expv); end
            n_checks++; if (obs_lat != el) begin n_fail++; $display("FAIL rnd%0d_lat wr=%b sz=%b a=%h got=%0d exp=%0d", i, wr, sz, a, obs_lat, el); end
            n_checks++; if (obs_we != ew) begin n_fail++; $display("FAIL rnd%0d_we got=%0d exp=%0d", i, obs_we, ew); end
            n_checks++; if (obs_rdy != 0) begin n_fail++; $display("FAIL rnd%0d_ready_busy got=%0d exp=0", i, obs_rdy); end
            n_checks++; if (mem[a[15:1]] !== refm[a[15:1]]) begin n_fail++; $display("FAIL rnd%0d_mem_w0 a=%h got=%h exp=%h", i, a, mem[a[15:1]], refm[a[15:1]]); end
            n_checks++; if (mem[a1[15:1]] !== refm[a1[15:1]]) begin n_fail++; $display("FAIL rnd%0d_mem_w1 a=%h got=%h exp=%h", i, a, mem[a1[15:1]], refm[a1[15:1]]); end
        end
    endtask

    initial begin
        test_reset();
        test_byte_load();
        test_misaligned_load();
        test_byte_store();
        test_misaligned_store();
        test_wrap();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
